box_decimator: RTL and testbench
================================

// Module: box_decimator
//
// PURPOSE
//   Downstream stage of box_filter. Takes the filtered 32-bit sample stream
//   and keeps one sample in every DECIM_FACTOR. Buffers the kept samples in
//   a DEPTH-entry first-word-fall-through FIFO and presents them on a
//   valid/ready interface to the consumer (checker or host model).
//   Overflow is reported and counted; samples are never silently lost.
//
// PARAMETERS
//   DECIM_FACTOR  4   keep 1 of every DECIM_FACTOR input samples; >=1 (1 = keep all)
//   DEPTH         8   FIFO entries; power of two, >=2
//   DATA_W        32  sample width; matches box_filter out
//
// PORTS
//   clk        in   1                  clock, all state on posedge
//   rst_n      in   1                  asynchronous, active-low reset
//   in_valid   in   1                  in carries a new filtered sample this cycle
//   in         in   DATA_W             filtered sample (box_filter out)
//   out_data   out  DATA_W             FIFO head sample
//   out_valid  out  1                  FIFO non-empty; out_data is meaningful
//   out_ready  in   1                  consumer accepts head this cycle
//   count      out  $clog2(DEPTH)+1    current FIFO occupancy, 0..DEPTH
//   overflow   out  1                  sticky: a kept sample was dropped
//   drop_cnt   out  16                 dropped-sample count, saturates at 16'hFFFF
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): phase=0; FIFO pointers=0; count=0;
//     out_valid=0; out_data=0; overflow=0; drop_cnt=0.
//     FIFO storage is cleared to 0.
//   - Reset mid-stream discards all buffered samples. The first in_valid
//     after release starts a new decimation group.
//   - Phase counter 0..DECIM_FACTOR-1:
//     - Advances only on in_valid and wraps to 0.
//     - A sample is "kept" when in_valid and phase==DECIM_FACTOR-1, i.e. the
//       last sample of each group.
//     - DECIM_FACTOR=1 keeps every valid sample.
//   - push = kept; pop = out_valid & out_ready.
//   - Latency: a sample kept at posedge t is visible at out_data with
//     out_valid=1 after posedge t (one cycle). There is no combinational
//     in->out path.
//   - FWFT: out_data == storage[rd_ptr] whenever out_valid=1. When out_valid=0,
//     out_data holds its last value (0 after reset).
//   - Handshake:
//     - out_data must stay stable while out_valid=1 and out_ready=0.
//     - out_ready while out_valid=0 has no effect.
//   - Pointers are $clog2(DEPTH) bits and wrap naturally. count is updated
//     +1 on push-only, -1 on pop-only, unchanged on both or neither.
//   - Full and push with pop in the same cycle: the pop frees the slot and
//     the push is accepted. count stays DEPTH; no overflow.
//   - Full and push without pop: the sample is dropped and storage is
//     unchanged. overflow<=1 (sticky until reset). drop_cnt+=1, saturating.
//   - Empty and push: stored, and out_valid rises the next cycle. The push
//     is not bypassed to the output.
//   - in_valid=0: phase, FIFO and flags are unchanged; pops still proceed.
//   - All arithmetic is unsigned. Samples are passed unmodified; no rounding
//     or truncation.
//
// TESTING
//   1 DECIM=4, DEPTH=8; in=1..8 on consecutive in_valid, out_ready=1
//     -> outputs 4 then 8. Each appears 1 cycle after kept; overflow=0.
//   2 Reset release, then in=10,20,30 with in_valid gaps between them
//     -> no output. A 4th sample 40 -> out_data=40 with out_valid=1.
//   3 out_ready=0; feed 36 samples (9 kept: 4,8,...,36)
//     -> count=8; 36 is dropped, overflow=1, drop_cnt=1.
//     Then drain -> 4,8,...,32 in order.
//   4 FIFO full, out_ready=1 in the same cycle a sample is kept
//     -> count stays 8, overflow stays 0, the new sample is at the tail.
//   5 Three samples buffered, then rst_n pulsed low asynchronously
//     mid-cycle -> out_valid=0, count=0, out_data=0 immediately.
//     The next group of 4 yields its 4th sample.
//   6 DECIM=1 with random 16-bit samples vs box_filter output, random
//     out_ready -> the output sequence equals the input sequence exactly
//     while no overflow occurs.

Source files
------------

// File: rtl/box_decimator.sv
// box_decimator
//
// Keeps the last sample of every DECIM_FACTOR-sample group from the box_filter
// output stream and buffers the kept samples in a DEPTH-entry first-word-fall-through
// FIFO. The consumer reads the FIFO through a valid/ready handshake. A kept sample
// that arrives while the FIFO is full and nothing is popped is dropped. The drop
// sets a sticky overflow flag and is counted in a saturating counter.
//
// Ports
//   clk        in   1                clock, all state on posedge
//   rst_n      in   1                asynchronous active-low reset
//   in_valid   in   1                in carries a new filtered sample
//   in         in   DATA_W           filtered sample
//   out_data   out  DATA_W           FIFO head sample (holds last value when empty)
//   out_valid  out  1                FIFO non-empty
//   out_ready  in   1                consumer accepts the head this cycle
//   count      out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
//   overflow   out  1                sticky: a kept sample was dropped
//   drop_cnt   out  16               dropped-sample count, saturating

module box_decimator #(
    parameter int unsigned DECIM_FACTOR = 4,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned DATA_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    // A factor of 1 still gets a 1-bit phase register that simply stays at 0.
    localparam int unsigned PW = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM_FACTOR - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    // State
    logic [PW-1:0]     phase_q, phase_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    // Per-cycle decode
    logic kept;
    logic full;
    logic pop;
    logic push_ok;
    logic drop;

    always_comb begin
        kept    = in_valid && (phase_q == PHASE_LAST);
        full    = (count_q == COUNT_FULL);
        pop     = (count_q != '0) && out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok = kept && (!full || pop);
        drop    = kept && full && !pop;
    end

    // Decimation phase: counts valid samples within a group.
    always_comb begin
        phase_d = phase_q;
        if (in_valid) begin
            if (kept) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

    // FIFO storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = in;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Registered head. It tracks the entry at the next read pointer, including a
    // sample written this cycle, and keeps the last head once the FIFO drains.
    always_comb begin
        out_data_d = out_data_q;
        if (count_d != '0) begin
            out_data_d = mem_d[rd_ptr_d];
        end
    end

    // Overflow reporting.
    always_comb begin
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_box_decimator.sv
// tb_box_decimator
//
// Self-checking bench for box_decimator. Instance a uses DECIM_FACTOR=4 and
// instance b uses DECIM_FACTOR=1. Both use DEPTH=8 and DATA_W=32.
// Inputs are driven on the falling edge and outputs are checked on the falling
// edge. The reference model treats the FIFO as a queue of kept samples.

module tb_box_decimator;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance a (DECIM=4)
    logic        a_in_valid = 1'b0;
    logic [31:0] a_in       = '0;
    logic        a_ready    = 1'b0;
    logic [31:0] a_out_data;
    logic        a_out_valid;
    logic [3:0]  a_count;
    logic        a_overflow;
    logic [15:0] a_drop_cnt;

    // Instance b (DECIM=1)
    logic        b_in_valid = 1'b0;
    logic [31:0] b_in       = '0;
    logic        b_ready    = 1'b0;
    logic [31:0] b_out_data;
    logic        b_out_valid;
    logic [3:0]  b_count;
    logic        b_overflow;
    logic [15:0] b_drop_cnt;

    int errors = 0;
    int checks = 0;

    box_decimator #(.DECIM_FACTOR(4), .DEPTH(8), .DATA_W(32)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in        (a_in),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_ready),
        .count     (a_count),
        .overflow  (a_overflow),
        .drop_cnt  (a_drop_cnt)
    );

    box_decimator #(.DECIM_FACTOR(1), .DEPTH(8), .DATA_W(32)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in        (b_in),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_ready),
        .count     (b_count),
        .overflow  (b_overflow),
        .drop_cnt  (b_drop_cnt)
    );

    // Reference model: the n-th valid sample (from 0) is kept when n % D == D-1.
    // The FIFO is a queue of at most 8 entries, popped before the push.
    int unsigned a_nvalid = 0;
    logic [31:0] a_mq[$];
    bit          a_m_ovf  = 1'b0;
    int unsigned a_m_drop = 0;
    logic [31:0] a_m_last = '0;
    bit          a_pop, a_keep;

    int unsigned b_nvalid = 0;
    logic [31:0] b_mq[$];
    bit          b_m_ovf  = 1'b0;
    int unsigned b_m_drop = 0;
    logic [31:0] b_m_last = '0;
    bit          b_pop, b_keep;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                a_nvalid = 0; a_mq.delete(); a_m_ovf = 1'b0; a_m_drop = 0; a_m_last = '0;
                b_nvalid = 0; b_mq.delete(); b_m_ovf = 1'b0; b_m_drop = 0; b_m_last = '0;
            end else begin
                a_pop  = (a_mq.size() != 0) && a_ready;
                a_keep = a_in_valid && ((a_nvalid % 4) == 3);
                if (a_in_valid) a_nvalid++;
                if (a_pop) void'(a_mq.pop_front());
                if (a_keep) begin
                    if (a_mq.size() < 8) a_mq.push_back(a_in);
                    else begin
                        a_m_ovf = 1'b1;
                        if (a_m_drop < 65535) a_m_drop++;
                    end
                end
                if (a_mq.size() != 0) a_m_last = a_mq[0];

                b_pop  = (b_mq.size() != 0) && b_ready;
                b_keep = b_in_valid;
                if (b_in_valid) b_nvalid++;
                if (b_pop) void'(b_mq.pop_front());
                if (b_keep) begin
                    if (b_mq.size() < 8) b_mq.push_back(b_in);
                    else begin
                        b_m_ovf = 1'b1;
                        if (b_m_drop < 65535) b_m_drop++;
                    end
                end
                if (b_mq.size() != 0) b_m_last = b_mq[0];
            end
        end
    end

    task automatic drive_a(input bit v, input logic [31:0] d, input bit r);
        a_in_valid = v;
        a_in       = d;
        a_ready    = r;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        a_in_valid = 1'b0;
        a_ready    = 1'b0;
        b_in_valid = 1'b0;
        b_ready    = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", a_out_data); end
        checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", a_count); end
        checks++; if (a_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", a_overflow); end
        checks++; if (a_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", a_drop_cnt); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b want 0", b_out_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] exp_d;
        bit          exp_v;
        for (int k = 1; k <= 8; k++) begin
            drive_a(1'b1, 32'(k), 1'b1);
            exp_v = (k == 4) || (k == 8);
            exp_d = (k >= 8) ? 32'd8 : (k >= 4) ? 32'd4 : 32'd0;
            checks++; if (a_out_valid !== exp_v) begin errors++; $display("FAIL basic_valid k=%0d: got %b want %b", k, a_out_valid, exp_v); end
            checks++; if (a_out_data !== exp_d) begin errors++; $display("FAIL basic_data k=%0d: got %0d want %0d", k, a_out_data, exp_d); end
            checks++; if (a_count !== (exp_v ? 4'd1 : 4'd0)) begin errors++; $display("FAIL basic_count k=%0d: got %0d want %0d", k, a_count, exp_v); end
        end
        drive_a(1'b0, 32'd0, 1'b1);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== 32'd8) begin errors++; $display("FAIL basic_hold: got %0d want 8", a_out_data); end
        checks++; if (a_overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b want 0", a_overflow); end
    endtask

    task automatic test_gaps();
        int vals [8] = '{10, 999, 20, 999, 999, 30, 999, 40};
        bit vlds [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        pulse_reset();
        checks++; if (a_out_data !== 32'd0) begin errors++; $display("FAIL gaps_reset_data: got %0d want 0", a_out_data); end
        for (int i = 0; i < 8; i++) begin
            drive_a(vlds[i], 32'(vals[i]), 1'b0);
            if (i < 7) begin
                checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL gaps_early i=%0d: got %b want 0", i, a_out_valid); end
            end
        end
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL gaps_valid: got %b want 1", a_out_valid); end
        checks++; if (a_out_data !== 32'd40) begin errors++; $display("FAIL gaps_data: got %0d want 40", a_out_data); end
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b0, 32'd77, 1'b0);
            checks++; if (a_out_data !== 32'd40 || a_out_valid !== 1'b1) begin errors++; $display("FAIL gaps_stall: got %0d/%b want 40/1", a_out_data, a_out_valid); end
        end
        drive_a(1'b0, 32'd0, 1'b1);
        checks++; if (a_out_valid !== 1'b0 || a_count !== 4'd0) begin errors++; $display("FAIL gaps_pop: got valid %b count %0d want 0/0", a_out_valid, a_count); end
        checks++; if (a_out_data !== 32'd40) begin errors++; $display("FAIL gaps_hold: got %0d want 40", a_out_data); end
    endtask

    task automatic test_overflow();
        pulse_reset();
        for (int k = 1; k <= 36; k++) begin
            drive_a(1'b1, 32'(k), 1'b0);
            if (k == 35) begin
                checks++; if (a_overflow !== 1'b0 || a_count !== 4'd8) begin errors++; $display("FAIL ovf_pre: got ovf %b count %0d want 0/8", a_overflow, a_count); end
            end
        end
        a_in_valid = 1'b0;
        checks++; if (a_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d want 8", a_count); end
        checks++; if (a_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", a_overflow); end
        checks++; if (a_drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt: got %0d want 1", a_drop_cnt); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'(4 * (i + 1))) begin errors++; $display("FAIL ovf_drain i=%0d: got %0d/%b want %0d/1", i, a_out_data, a_out_valid, 4 * (i + 1)); end
            drive_a(1'b0, 32'd0, 1'b1);
        end
        checks++; if (a_out_valid !== 1'b0 || a_count !== 4'd0) begin errors++; $display("FAIL ovf_empty: got %b/%0d want 0/0", a_out_valid, a_count); end
        checks++; if (a_overflow !== 1'b1 || a_drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_sticky: got %b/%0d want 1/1", a_overflow, a_drop_cnt); end
    endtask

    task automatic test_full_push_pop();
        pulse_reset();
        for (int k = 1; k <= 35; k++) drive_a(1'b1, 32'(100 + k), 1'b0);
        checks++; if (a_count !== 4'd8 || a_overflow !== 1'b0) begin errors++; $display("FAIL fpp_full: got %0d/%b want 8/0", a_count, a_overflow); end
        drive_a(1'b1, 32'd136, 1'b1);
        a_in_valid = 1'b0;
        a_ready    = 1'b0;
        checks++; if (a_count !== 4'd8) begin errors++; $display("FAIL fpp_count: got %0d want 8", a_count); end
        checks++; if (a_overflow !== 1'b0 || a_drop_cnt !== 16'd0) begin errors++; $display("FAIL fpp_no_ovf: got %b/%0d want 0/0", a_overflow, a_drop_cnt); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (a_out_data !== 32'(108 + 4 * i)) begin errors++; $display("FAIL fpp_drain i=%0d: got %0d want %0d", i, a_out_data, 108 + 4 * i); end
            drive_a(1'b0, 32'd0, 1'b1);
        end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b want 0", a_out_valid); end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        for (int k = 1; k <= 14; k++) drive_a(1'b1, 32'(200 + k), 1'b0);
        a_in_valid = 1'b0;
        checks++; if (a_count !== 4'd3) begin errors++; $display("FAIL arst_pre_count: got %0d want 3", a_count); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", a_out_valid); end
        checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", a_count); end
        checks++; if (a_out_data !== 32'd0) begin errors++; $display("FAIL arst_data: got %0d want 0", a_out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive_a(1'b1, 32'(300 + k), 1'b1);
            checks++; if (a_out_valid !== (k == 4)) begin errors++; $display("FAIL arst_group k=%0d: got %b want %b", k, a_out_valid, k == 4); end
        end
        checks++; if (a_out_data !== 32'd304) begin errors++; $display("FAIL arst_data4: got %0d want 304", a_out_data); end
        a_in_valid = 1'b0;
    endtask

    task automatic test_random_a();
        bit v, r;
        pulse_reset();
        for (int c = 0; c < 600; c++) begin
            v = ($urandom_range(0, 1) == 1);
            r = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive_a(v, $urandom, r);
            checks++; if (a_out_valid !== (a_mq.size() != 0)) begin errors++; $display("FAIL rnda_valid c=%0d: got %b want %b", c, a_out_valid, a_mq.size() != 0); end
            checks++; if (a_out_data !== a_m_last) begin errors++; $display("FAIL rnda_data c=%0d: got %h want %h", c, a_out_data, a_m_last); end
            checks++; if (a_count !== 4'(a_mq.size())) begin errors++; $display("FAIL rnda_count c=%0d: got %0d want %0d", c, a_count, a_mq.size()); end
            checks++; if (a_overflow !== a_m_ovf || a_drop_cnt !== 16'(a_m_drop)) begin errors++; $display("FAIL rnda_ovf c=%0d: got %b/%0d want %b/%0d", c, a_overflow, a_drop_cnt, a_m_ovf, a_m_drop); end
        end
        a_in_valid = 1'b0;
        a_ready    = 1'b0;
    endtask

    task automatic test_random_b();
        logic [31:0] hist[$];
        pulse_reset();
        for (int c = 0; c < 1500; c++) begin
            b_in_valid = ($urandom_range(0, 9) < 4);
            b_in       = 32'($urandom_range(0, 65535));
            b_ready    = ($urandom_range(0, 3) != 0);
            // Output order must equal input order while nothing has been dropped.
            if (b_out_valid && b_ready && !b_m_ovf) begin
                checks++;
                if (hist.size() == 0 || b_out_data !== hist[0]) begin
                    errors++;
                    $display("FAIL rndb_order c=%0d: got %h want %h", c, b_out_data,
                             (hist.size() != 0) ? hist[0] : 32'hx);
                end
                if (hist.size() != 0) void'(hist.pop_front());
            end
            if (b_in_valid) hist.push_back(b_in);
            @(negedge clk);
            checks++; if (b_out_valid !== (b_mq.size() != 0) || b_count !== 4'(b_mq.size())) begin errors++; $display("FAIL rndb_occ c=%0d: got %b/%0d want %0d", c, b_out_valid, b_count, b_mq.size()); end
            checks++; if (b_out_data !== b_m_last) begin errors++; $display("FAIL rndb_data c=%0d: got %h want %h", c, b_out_data, b_m_last); end
        end
        b_in_valid = 1'b0;
        checks++; if (b_overflow !== b_m_ovf || b_drop_cnt !== 16'(b_m_drop)) begin errors++; $display("FAIL rndb_ovf: got %b/%0d want %b/%0d", b_overflow, b_drop_cnt, b_m_ovf, b_m_drop); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_full_push_pop();
        test_async_reset();
        test_random_a();
        test_random_b();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
